// File: rtl/dl_fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dl_fwd_pkg
// Purpose : Shared types for the operand-bypass controller. Holds the
//           mux-select encoding, the X/M/W stage entry layout and the
//           select width.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package dl_fwd_pkg;

    localparam int FWD_SEL_BITS = 3;
    // Width of the rd field inside a stage entry. The controller's
    // REG_ADDR_BITS parameter must equal this value.
    localparam int FWD_RD_BITS  = 5;

    typedef enum logic [FWD_SEL_BITS-1:0] {
        FWD_RF  = 3'd0,
        FWD_X   = 3'd1,
        FWD_M   = 3'd2,
        FWD_W   = 3'd3,
        FWD_IMM = 3'd4
    } fwd_sel_e;

    typedef struct packed {
        logic                   val;
        logic                   wen;
        logic                   ld;
        logic [FWD_RD_BITS-1:0] rd;
    } fwd_entry_t;

endpackage : dl_fwd_pkg
`default_nettype wire

// File: rtl/dl_fwd_match.sv
`default_nettype none
// ============================================================================
// Module  : dl_fwd_match
// Purpose : Combinational select for one source operand. Picks the
//           youngest in-flight producer of rs (X > M > W), the immediate,
//           or the register file, and flags a winner whose data is not
//           yet available.
// Ports   : rs, rs_use, rs_imm   - source index / read enable / imm select
//           x_ent, m_ent, w_ent  - stage entries
//           sel                  - 3-bit mux select
//           not_rdy              - winning producer is a load still in X
// Revision: 1.0 - initial release
// ============================================================================
module dl_fwd_match
    import dl_fwd_pkg::*;
#(
    parameter int REG_ADDR_BITS = FWD_RD_BITS
) (
    input  logic [REG_ADDR_BITS-1:0] rs,
    input  logic                     rs_use,
    input  logic                     rs_imm,
    input  fwd_entry_t               x_ent,
    input  fwd_entry_t               m_ent,
    input  fwd_entry_t               w_ent,
    output logic [FWD_SEL_BITS-1:0]  sel,
    output logic                     not_rdy
);

    logic w_hit_x;
    logic w_hit_m;
    logic w_hit_w;
    logic w_rs_zero;

    // x0 is hard-wired zero, so an entry with rd=0 never needs a bypass;
    // checking rs against zero once covers that for every stage.
    assign w_rs_zero = (rs == '0);
    assign w_hit_x   = x_ent.val & x_ent.wen & (x_ent.rd == rs);
    assign w_hit_m   = m_ent.val & m_ent.wen & (m_ent.rd == rs);
    assign w_hit_w   = w_ent.val & w_ent.wen & (w_ent.rd == rs);

    always_comb begin
        sel     = FWD_RF;
        not_rdy = 1'b0;
        if (rs_imm) begin
            sel = FWD_IMM;
        end else if (rs_use && !w_rs_zero) begin
            if (w_hit_x) begin
                sel     = FWD_X;
                not_rdy = x_ent.ld;   // load data only exists from M onward
            end else if (w_hit_m) begin
                sel = FWD_M;
            end else if (w_hit_w) begin
                sel = FWD_W;
            end
        end
    end

endmodule : dl_fwd_match
`default_nettype wire

// File: rtl/dl_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dl_fwd_ctrl
// Purpose : Operand-bypass controller at the decode/issue boundary. Tracks
//           the destination of the instructions in X, M and W, drives one
//           3-bit operand-mux select per source and raises a load-use stall.
// Ports   : clk, rst (async, active-high)
//           issue_val_i/wen_i/ld_i/rd_i - decode instruction descriptor
//           rs_addr_i/rs_use_i/rs_imm_i - per-source fields, src0 in LSBs
//           ext_stall_i - freeze X/M/W; flush_i - kill decode and X
//           sel_o - mux selects, stall_o - load-use stall
//           x_val_o/m_val_o/w_val_o - stage valids
//           stall_cnt_o - saturating load-use stall counter (only when
//                         DL_FWD_STALL_CNT_EN is defined)
// Revision: 1.0 - initial release
// ============================================================================
module dl_fwd_ctrl
    import dl_fwd_pkg::*;
#(
    parameter int NUM_SRC       = 2,
    parameter int REG_ADDR_BITS = FWD_RD_BITS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             issue_val_i,
    input  logic                             issue_wen_i,
    input  logic                             issue_ld_i,
    input  logic [REG_ADDR_BITS-1:0]         issue_rd_i,
    input  logic [NUM_SRC*REG_ADDR_BITS-1:0] rs_addr_i,
    input  logic [NUM_SRC-1:0]               rs_use_i,
    input  logic [NUM_SRC-1:0]               rs_imm_i,
    input  logic                             ext_stall_i,
    input  logic                             flush_i,
    output logic [NUM_SRC*FWD_SEL_BITS-1:0]  sel_o,
    output logic                             stall_o,
`ifdef DL_FWD_STALL_CNT_EN
    output logic [31:0]                      stall_cnt_o,
`endif
    output logic                             x_val_o,
    output logic                             m_val_o,
    output logic                             w_val_o
);

    fwd_entry_t             r_x;
    fwd_entry_t             r_m;
    fwd_entry_t             r_w;
    fwd_entry_t             w_dec;
    logic [NUM_SRC-1:0]     w_not_rdy;
    logic [FWD_SEL_BITS-1:0] w_sel [NUM_SRC];

    generate
        for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
            dl_fwd_match #(
                .REG_ADDR_BITS (REG_ADDR_BITS)
            ) u_match (
                .rs      (rs_addr_i[s*REG_ADDR_BITS +: REG_ADDR_BITS]),
                .rs_use  (rs_use_i[s]),
                .rs_imm  (rs_imm_i[s]),
                .x_ent   (r_x),
                .m_ent   (r_m),
                .w_ent   (r_w),
                .sel     (w_sel[s]),
                .not_rdy (w_not_rdy[s])
            );
            // Selects are forced to RF while reset is asserted, even if the
            // decode fields ask for the immediate.
            assign sel_o[s*FWD_SEL_BITS +: FWD_SEL_BITS] = rst ? '0 : w_sel[s];
        end
    endgenerate

    assign stall_o = ~rst & issue_val_i & (|w_not_rdy);

    assign w_dec.val = 1'b1;
    assign w_dec.wen = issue_wen_i;
    assign w_dec.ld  = issue_ld_i;
    assign w_dec.rd  = issue_rd_i;

    // Flush outranks the external stall: a redirect must drain X and M even
    // while the back end is frozen. The W<=M move keeps the older, already
    // committed-path instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_m <= '0;
            r_w <= '0;
        end else if (flush_i) begin
            r_x <= '0;
            r_m <= '0;
            r_w <= r_m;
        end else if (!ext_stall_i) begin
            r_w <= r_m;
            r_m <= r_x;
            r_x <= (issue_val_i && !stall_o) ? w_dec : '0;
        end
    end

    assign x_val_o = r_x.val;
    assign m_val_o = r_m.val;
    assign w_val_o = r_w.val;

`ifdef DL_FWD_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Only cycles where the stall really cost a decode slot are counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (issue_val_i && stall_o && !ext_stall_i && !flush_i &&
                     (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule : dl_fwd_ctrl
`default_nettype wire

// File: doc/dl_fwd_ctrl.md
Name: dl_fwd_ctrl

Overview:
- Operand-bypass controller; sits directly upstream of the 5-to-1 operand muxes (one per source operand) at the decode/issue boundary of the RISC-V pipeline.
- Tracks destination registers of in-flight instructions in the X, M and W stages.
- Drives each mux's 3-bit select to pick the freshest value: regfile, X/M/W result, or immediate.
- Raises a load-use stall when the freshest producer's data is not yet available.

Parameters:
- NUM_SRC, 2, number of source operands (one 3-bit select each).
- REG_ADDR_BITS, 5, architectural register index width.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous, active-high reset
- issue_val_i  input  1  decode-stage instruction valid
- issue_wen_i  input  1  decode instruction writes rd
- issue_ld_i  input  1  decode instruction is a load; result available from M onward
- issue_rd_i  input  REG_ADDR_BITS  decode destination register
- rs_addr_i  input  NUM_SRC*REG_ADDR_BITS  source register indices, src0 in LSBs
- rs_use_i  input  NUM_SRC  source actually read
- rs_imm_i  input  NUM_SRC  source takes immediate/PC (mux in4)
- ext_stall_i  input  1  downstream stall; freezes X/M/W
- flush_i  input  1  kill decode and X instructions (branch redirect)
- sel_o  output  NUM_SRC*3  mux selects, src0 in LSBs
- stall_o  output  1  load-use stall; decode must hold
- x_val_o, m_val_o, w_val_o  output  1 each  stage entry valid (debug/observability)

Behaviour:
- Stage entry: {val, wen, ld, rd}. Three entries X, M, W.
- Reset: all entries cleared (val=0). Outputs during reset: sel_o=0 for all sources, stall_o=0, stage valids 0.
- Select encoding: 0=RF, 1=X, 2=M, 3=W, 4=IMM.
- Select logic (combinational, zero latency) per source s:
  - rs_imm_i[s] -> 4.
  - Else if !rs_use_i[s] or rs==0 -> 0. x0 is never forwarded.
  - Else the youngest matching entry wins, priority X > M > W. A match requires val & wen & rd==rs.
  - No match -> 0.
- Readiness:
  - X entry with ld=1 is not ready; all M and W entries are ready.
  - stall_o=1 iff issue_val_i and some source's winning match is a non-ready X entry.
  - When stall_o=1, sel_o still shows the would-be select; it is don't-care to the consumer.
- Sequencing (posedge clk), in priority order:
  - flush_i=1, regardless of ext_stall_i: X<=bubble, M<=bubble, W<=M. Decode is not inserted.
  - Else ext_stall_i=1: all entries hold; stall_o is still computed.
  - Else: W<=M, M<=X. X<=decode entry if issue_val_i & !stall_o, else bubble.
- Bubble: val=0, other fields zero.
- Entry with wen=0 or rd=0: stored as given but never matches.
- Simultaneous stall_o and ext_stall_i: hold; the load advances once ext_stall_i drops.
- Reset mid-operation: async clear; the pipeline restarts empty on the first clk after rst deasserts.
- No internal counters other than the optional feature.

Optional Feature:
- Macro: DL_FWD_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt_o, 32 bits.
  - Increments on each clk where issue_val_i & stall_o & !ext_stall_i & !flush_i.
  - Saturates at 0xFFFF_FFFF. Reset to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package dl_fwd_pkg:
  - Enum fwd_sel_e (FWD_RF=3'd0, FWD_X, FWD_M, FWD_W, FWD_IMM=3'd4).
  - Packed struct fwd_entry_t {val, wen, ld, rd}.
  - Localparam FWD_SEL_BITS=3.
- Sub-module dl_fwd_match: purely combinational, one per source, generated NUM_SRC times. Inputs: rs, use, imm, X/M/W entries. Outputs: select and not-ready flag.
- Top-level module owns the stage registers, stall/flush sequencing and the optional counter.

Test Plan:
- Reset, then issue ADD rd=5 and the next instruction reads rs0=5 -> sel src0=1 (X). After one advance with no new producer -> 2, then 3, then 0.
- Back-to-back writers to x7 reach X and M; reader of rs1=7 -> sel src1=1 (X beats M), stall_o=0.
- LW rd=3 in X; decode reads rs0=3 -> stall_o=1, X gets a bubble. Next cycle load is in M -> sel=2, stall_o=0.
- Reader with rs=0 and an X entry with rd=0,wen=1 -> sel=0. Reader with rs_imm_i=1 -> sel=4 regardless of matches.
- ext_stall_i held 3 cycles with the load in X -> entries frozen, stall_o stays 1. flush_i asserted during ext_stall_i -> X and M become invalid and W takes the old M.
- DL_FWD_STALL_CNT_EN build: 4 load-use stall cycles, one of them masked by ext_stall_i -> stall_cnt_o=3. Assert rst -> stall_cnt_o=0.
